// File: rtl/bicubic_symmetric_mux_mp.sv
// Bicubic symmetric reference-pixel mux, multi-phase: reorders one 4x4 window into L/H DSP
// groups (row/column symmetry) and serialises each 8-pixel group over PHASES output beats.
module bicubic_symmetric_mux_mp #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned PHASES      = 2,
    localparam int unsigned SLOTS      = 8 / PHASES,
    localparam int unsigned GRP_W      = SLOTS * PIXEL_WIDTH,
    localparam int unsigned PH_W       = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      sym_y,
    input  logic                      sym_x,
    input  logic [16*PIXEL_WIDTH-1:0] px_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [GRP_W-1:0]          grp_l_out,
    output logic [GRP_W-1:0]          grp_h_out,
    output logic [PH_W-1:0]           out_phase,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned WIN_W = 8 * PIXEL_WIDTH;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(PHASES - 1);

    if (!(PHASES == 1 || PHASES == 2 || PHASES == 4 || PHASES == 8)) begin : g_bad_phases
        $error("bicubic_symmetric_mux_mp: PHASES must be 1, 2, 4 or 8");
    end

    typedef enum logic [0:0] {StEmpty, StHold} state_e;

    state_e           state_q;
    logic [WIN_W-1:0] buf_l_q, buf_h_q;
    logic [WIN_W-1:0] win_l, win_h;
    logic             accept, beat_done;
    logic [PH_W-1:0]  nxt_phase;
    logic [GRP_W-1:0] nxt_l, nxt_h;

    // Static slot wiring; only the row mirror and the L/H swap are run-time selects.
    for (genvar k = 0; k < 8; k++) begin : g_slot
        localparam int unsigned ROW   = 2 * (k / 4) + (k % 2);
        localparam int unsigned COL_L = 3 - ((k / 2) % 2);
        localparam int unsigned COL_H = (k / 2) % 2;

        logic [PIXEL_WIDTH-1:0] l_dir, l_mir, h_dir, h_mir, pix_l, pix_h;

        assign l_dir = px_in[(4 * ROW + COL_L) * PIXEL_WIDTH +: PIXEL_WIDTH];
        assign l_mir = px_in[(4 * (3 - ROW) + COL_L) * PIXEL_WIDTH +: PIXEL_WIDTH];
        assign h_dir = px_in[(4 * ROW + COL_H) * PIXEL_WIDTH +: PIXEL_WIDTH];
        assign h_mir = px_in[(4 * (3 - ROW) + COL_H) * PIXEL_WIDTH +: PIXEL_WIDTH];

        assign pix_l = sym_y ? l_mir : l_dir;
        assign pix_h = sym_y ? h_mir : h_dir;

        assign win_l[k*PIXEL_WIDTH +: PIXEL_WIDTH] = sym_x ? pix_h : pix_l;
        assign win_h[k*PIXEL_WIDTH +: PIXEL_WIDTH] = sym_x ? pix_l : pix_h;
    end

    assign beat_done = clken & out_valid & out_ready;
    // A new window may enter on the very cycle the last beat of the current one leaves.
    assign in_ready  = clken & ~reset &
                       ((state_q == StEmpty) | (out_valid & out_ready & out_last));
    assign accept    = in_valid & in_ready;

    always_comb begin
        nxt_phase = out_phase + 1'b1;
        nxt_l     = buf_l_q[GRP_W-1:0];
        nxt_h     = buf_h_q[GRP_W-1:0];
        for (int i = 1; i < int'(PHASES); i++) begin
            if (nxt_phase == PH_W'(i)) begin
                nxt_l = buf_l_q[i*GRP_W +: GRP_W];
                nxt_h = buf_h_q[i*GRP_W +: GRP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StEmpty;
            buf_l_q   <= '0;
            buf_h_q   <= '0;
            out_valid <= 1'b0;
            out_phase <= '0;
            out_last  <= (PHASES == 1);
            grp_l_out <= '0;
            grp_h_out <= '0;
        end else if (clken) begin
            if (accept) begin
                state_q   <= StHold;
                buf_l_q   <= win_l;
                buf_h_q   <= win_h;
                out_valid <= 1'b1;
                out_phase <= '0;
                out_last  <= (PHASES == 1);
                grp_l_out <= win_l[GRP_W-1:0];
                grp_h_out <= win_h[GRP_W-1:0];
            end else if (beat_done) begin
                if (out_last) begin
                    state_q   <= StEmpty;
                    out_valid <= 1'b0;
                end else begin
                    out_phase <= nxt_phase;
                    out_last  <= (nxt_phase == LAST_PH);
                    grp_l_out <= nxt_l;
                    grp_h_out <= nxt_h;
                end
            end
        end
    end

endmodule
